// File: rtl/adc_iface_pkg.sv
// Shared constants for the ADC capture/decimation front-end.
// Mode encodings, LED bit positions and drop counter width.
package adc_iface_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  localparam int DROP_W   = 8;

  localparam int LED_HI   = 5;
  localparam int LED_OVF  = 4;
  localparam int LED_DROP = 3;
  localparam int LED_LO   = 0;

endpackage

// File: rtl/adc_window_accum.sv
// Decimation window: counter, shadow config and boxcar accumulator.
// Emits a one-cycle result strobe on the last sample of each window.
module adc_window_accum
  import adc_iface_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 16,
  parameter int AVG_MAX_LOG2 = 8,
  parameter int SIGNED       = 0,
  localparam int SH_W        = $clog2(AVG_MAX_LOG2 + 1)
) (
  input  logic              clkouta,
  input  logic              rst_n,
  input  logic              en,
  input  logic              smp_vld,
  input  logic [DATA_W-1:0] smp,
  input  logic              smp_ovr,
  input  logic              mode,
  input  logic [CNT_W-1:0]  decim,
  input  logic [SH_W-1:0]   avg_log2,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovr,
  output logic              res_stb
);

  localparam int AW = DATA_W + AVG_MAX_LOG2;

  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic             ovr_acc;
  logic             mode_s;
  logic [CNT_W-1:0] decim_s;
  logic [SH_W-1:0]  sh_s;

  logic              start;
  logic              step;
  logic [SH_W-1:0]   sh_in;
  logic              mode_e;
  logic [CNT_W-1:0]  decim_e;
  logic [SH_W-1:0]   sh_e;
  logic [CNT_W-1:0]  last;
  logic [AW-1:0]     ext;
  logic [AW-1:0]     sum;
  logic signed [AW-1:0] sum_s;
  logic [AW-1:0]     shr;
  logic              ovr_sum;

  // At window start the live config applies; afterwards the shadow copy
  always_comb begin
    start   = (cnt == '0);
    step    = en & smp_vld;
    sh_in   = avg_log2;
    if (avg_log2 > SH_W'(AVG_MAX_LOG2))
      sh_in = SH_W'(AVG_MAX_LOG2);
    mode_e  = start ? mode  : mode_s;
    decim_e = start ? decim : decim_s;
    sh_e    = start ? sh_in : sh_s;
    if (mode_e == MODE_AVG)
      last = (CNT_W'(1) << sh_e) - CNT_W'(1);
    else
      last = decim_e;
    if (SIGNED != 0)
      ext = {{AVG_MAX_LOG2{smp[DATA_W-1]}}, smp};
    else
      ext = {{AVG_MAX_LOG2{1'b0}}, smp};
    sum     = (start ? '0 : acc) + ext;
    sum_s   = sum;
    ovr_sum = (start ? 1'b0 : ovr_acc) | smp_ovr;
    if (SIGNED != 0)
      shr = sum_s >>> sh_e;
    else
      shr = sum >> sh_e;
    res_stb = step && (cnt == last);
    if (mode_e == MODE_AVG) begin
      res_data = shr[DATA_W-1:0];
      res_ovr  = ovr_sum;
    end else begin
      res_data = smp;
      res_ovr  = smp_ovr;
    end
  end

  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      ovr_acc <= 1'b0;
      mode_s  <= MODE_PICK;
      decim_s <= '0;
      sh_s    <= '0;
    end else if (!en) begin
      cnt     <= '0;
      acc     <= '0;
      ovr_acc <= 1'b0;
    end else if (step) begin
      if (start) begin
        mode_s  <= mode;
        decim_s <= decim;
        sh_s    <= sh_in;
      end
      if (res_stb) begin
        cnt     <= '0;
        acc     <= '0;
        ovr_acc <= 1'b0;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        acc     <= sum;
        ovr_acc <= ovr_sum;
      end
    end
  end

endmodule

// File: rtl/adc_capture_decim.sv
// ADC capture front-end: input regs, decimation window, output stream.
// Also keeps drop accounting and sticky status for the board LEDs.
module adc_capture_decim
  import adc_iface_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 16,
  parameter int AVG_MAX_LOG2 = 8,
  parameter int SIGNED       = 0,
  localparam int SH_W        = $clog2(AVG_MAX_LOG2 + 1)
) (
  input  logic              clkouta,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ofa,
  input  logic              en,
  input  logic              mode,
  input  logic [CNT_W-1:0]  decim,
  input  logic [SH_W-1:0]   avg_log2,
  input  logic              clr_sticky,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [7:0]        led
);

  logic [DATA_W-1:0] d_q;
  logic              o_q;
  logic              vld_q;
  logic [DATA_W-1:0] res_data;
  logic              res_ovr;
  logic              res_stb;
  logic              load;
  logic              drop;
  logic              sticky_ovf;
  logic              sticky_drop;

  // vld_q marks that d_q holds a real sample rather than the reset value
  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      o_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      d_q   <= data_in;
      o_q   <= ofa;
      vld_q <= 1'b1;
    end
  end

  adc_window_accum #(
    .DATA_W       (DATA_W),
    .CNT_W        (CNT_W),
    .AVG_MAX_LOG2 (AVG_MAX_LOG2),
    .SIGNED       (SIGNED)
  ) u_win (
    .clkouta  (clkouta),
    .rst_n    (rst_n),
    .en       (en),
    .smp_vld  (vld_q),
    .smp      (d_q),
    .smp_ovr  (o_q),
    .mode     (mode),
    .decim    (decim),
    .avg_log2 (avg_log2),
    .res_data (res_data),
    .res_ovr  (res_ovr),
    .res_stb  (res_stb)
  );

  assign load = res_stb & (~out_valid | out_ready);
  assign drop = res_stb & out_valid & ~out_ready;

  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovr     <= 1'b0;
      drop_cnt    <= '0;
      sticky_ovf  <= 1'b0;
      sticky_drop <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= res_data;
        out_ovr   <= res_ovr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        if (clr_sticky)
          drop_cnt <= DROP_W'(1);
        else if (drop_cnt != '1)
          drop_cnt <= drop_cnt + DROP_W'(1);
      end else if (clr_sticky) begin
        drop_cnt <= '0;
      end
      sticky_ovf  <= (o_q & en) | (sticky_ovf & ~clr_sticky);
      sticky_drop <= drop | (sticky_drop & ~clr_sticky);
    end
  end

  // Data bits follow out_data, which only changes on a load
  always_comb begin
    led                = '0;
    led[LED_HI +: 3]   = out_data[DATA_W-1 -: 3];
    led[LED_OVF]       = sticky_ovf;
    led[LED_DROP]      = sticky_drop;
    led[LED_LO +: 3]   = out_data[2:0];
  end

endmodule

// File: tb/tb_adc_capture_decim.sv
// Bench for adc_capture_decim: per-scenario tasks checked against
// a window/queue reference model of the capture path.
module tb_adc_capture_decim;

  logic        clkouta = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        ofa;
  logic        en;
  logic        mode;
  logic [15:0] decim;
  logic [3:0]  avg_log2;
  logic        clr_sticky;
  logic [15:0] out_data;
  logic        out_ovr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_capture_decim #(
    .DATA_W       (16),
    .CNT_W        (16),
    .AVG_MAX_LOG2 (8),
    .SIGNED       (1)
  ) dut (
    .clkouta    (clkouta),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .ofa        (ofa),
    .en         (en),
    .mode       (mode),
    .decim      (decim),
    .avg_log2   (avg_log2),
    .clr_sticky (clr_sticky),
    .out_data   (out_data),
    .out_ovr    (out_ovr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt),
    .led        (led)
  );

  always #5 clkouta = ~clkouta;

  // Reference model: samples collected per window in a queue
  int          win[$];
  bit          wovr;
  bit          c_mode;
  int          c_dec;
  int          c_k;
  int          m_d;
  bit          m_o;
  bit          m_vld;
  bit          ev;
  bit          eovr;
  logic [15:0] edata;
  int          edrop;
  bit          s_ovf;
  bit          s_drop;

  task automatic model_reset();
    win.delete();
    wovr = 0; c_mode = 0; c_dec = 0; c_k = 0;
    m_d = 0; m_o = 0; m_vld = 0;
    ev = 0; eovr = 0; edata = '0;
    edrop = 0; s_ovf = 0; s_drop = 0;
  endtask

  task automatic model_step();
    bit          res;
    bit          drp;
    logic [15:0] rd;
    bit          ro;
    int          wlen;
    longint      s;
    longint      qt;
    res = 0; drp = 0; rd = '0; ro = 0;
    if (!en) begin
      win.delete();
      wovr = 0;
    end else if (m_vld) begin
      if (win.size() == 0) begin
        c_mode = mode;
        c_dec  = int'(decim);
        c_k    = (avg_log2 > 8) ? 8 : int'(avg_log2);
        wovr   = 0;
      end
      win.push_back(m_d);
      wovr = wovr | m_o;
      wlen = c_mode ? (1 << c_k) : c_dec + 1;
      if (win.size() == wlen) begin
        res = 1;
        if (c_mode) begin
          s = 0;
          foreach (win[i]) s += win[i];
          qt = s / wlen;
          if ((s % wlen != 0) && (s < 0)) qt = qt - 1;
          rd = qt[15:0];
          ro = wovr;
        end else begin
          rd = m_d[15:0];
          ro = m_o;
        end
        win.delete();
      end
    end
    if (res) begin
      if (!ev || out_ready) begin
        ev = 1; edata = rd; eovr = ro;
      end else begin
        drp = 1;
      end
    end else if (out_ready) begin
      ev = 0;
    end
    if (drp) edrop = clr_sticky ? 1 : (edrop == 255 ? 255 : edrop + 1);
    else if (clr_sticky) edrop = 0;
    if (m_o && en) s_ovf = 1;
    else if (clr_sticky) s_ovf = 0;
    if (drp) s_drop = 1;
    else if (clr_sticky) s_drop = 0;
    m_d   = int'($signed(data_in));
    m_o   = ofa;
    m_vld = 1;
  endtask

  task automatic tick();
    @(posedge clkouta);
    model_step();
    #1;
    cyc++;
  endtask

  function automatic logic [33:0] obs();
    return {out_valid, out_ovr, out_data, drop_cnt, led};
  endfunction

  function automatic logic [33:0] exp_vec();
    logic [7:0] l;
    l = {edata[15:13], s_ovf, s_drop, edata[2:0]};
    return {ev, eovr, edata, 8'(edrop), l};
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if (obs() !== 34'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h exp %h", obs(), 34'h0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs() !== 34'h0) begin
      errors++;
      $display("FAIL reset_release: got %h exp %h", obs(), 34'h0);
    end
  endtask

  task automatic test_pick();
    int first;
    int got[$];
    first = -1;
    for (int i = 0; i < 24; i++) begin
      data_in = 16'(i);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL pick_ramp c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
      if (out_valid) begin
        if (first < 0) first = i;
        got.push_back(int'(out_data));
      end
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL pick_latency: got %0d exp %0d", first, 4);
    end
    checks++;
    if (got.size() < 3 || got[0] !== 3 || got[1] !== 7 || got[2] !== 11) begin
      errors++;
      $display("FAIL pick_values: got %p exp 3,7,11", got);
    end
    for (int i = 0; i < 80; i++) begin
      data_in   = 16'($urandom);
      ofa       = ($urandom_range(0, 7) == 0);
      decim     = 16'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL pick_rand c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_avg();
    logic [15:0] smp[8];
    logic [15:0] want[2];
    int          nres;
    smp[0] = 16'h0004; smp[1] = 16'hFFFC; smp[2] = 16'h0003; smp[3] = 16'h0002;
    smp[4] = 16'hFFFF; smp[5] = 16'hFFFF; smp[6] = 16'hFFFF; smp[7] = 16'hFFFE;
    want[0] = 16'h0001;
    want[1] = 16'hFFFE;
    mode = 1'b1; avg_log2 = 4'd2; ofa = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      en = 1'b0;
      data_in = smp[w*4];
      tick();
      en = 1'b1;
      for (int i = 1; i < 5; i++) begin
        data_in = (i < 4) ? smp[w*4+i] : 16'($urandom);
        tick();
        checks++;
        if (obs() !== exp_vec()) begin
          errors++;
          $display("FAIL avg_dir c%0d: got %h exp %h", cyc, obs(), exp_vec());
        end
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== want[w]) begin
        errors++;
        $display("FAIL avg_val%0d: got v=%b d=%h exp v=1 d=%h", w, out_valid, out_data, want[w]);
      end
    end
    for (int i = 0; i < 120; i++) begin
      data_in   = 16'($urandom);
      ofa       = ($urandom_range(0, 9) == 0);
      avg_log2  = 4'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL avg_rand c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
    end
    avg_log2 = 4'hF; out_ready = 1'b1; en = 1'b0;
    tick();
    en = 1'b1;
    nres = 0;
    for (int i = 1; i <= 257; i++) begin
      data_in = 16'($urandom);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL avg_clamp c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
      if (out_valid) nres++;
    end
    checks++;
    if (nres !== 1) begin
      errors++;
      $display("FAIL avg_clamp_cnt: got %0d exp %0d", nres, 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] first;
    mode = 1'b0; decim = 16'd0; ofa = 1'b0;
    en = 1'b0; out_ready = 1'b1;
    tick();
    first = 16'hA5A5;
    data_in = first;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'($urandom);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_hold c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
    end
    checks++;
    if (out_data !== first || drop_cnt !== 8'd4 || led[3] !== 1'b1) begin
      errors++;
      $display("FAIL bp_drop: got d=%h cnt=%0d l3=%b exp d=%h cnt=4 l3=1", out_data, drop_cnt, led[3], first);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 16'($urandom);
      tick();
      checks++;
      if (obs() !== exp_vec() || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stream c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
    end
    out_ready = 1'b0;
    repeat (300) begin
      data_in = 16'($urandom);
      tick();
    end
    checks++;
    if (drop_cnt !== 8'd255 || obs() !== exp_vec()) begin
      errors++;
      $display("FAIL bp_sat: got cnt=%0d exp cnt=255", drop_cnt);
    end
    en = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0 || led[3] !== 1'b0) begin
      errors++;
      $display("FAIL bp_clr: got cnt=%0d l3=%b exp cnt=0 l3=0", drop_cnt, led[3]);
    end
  endtask

  task automatic test_overflow();
    bit ovr_seen[$];
    mode = 1'b1; avg_log2 = 4'd3; out_ready = 1'b1;
    en = 1'b0; ofa = 1'b0; clr_sticky = 1'b1;
    data_in = 16'($urandom);
    tick();
    clr_sticky = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_in = 16'($urandom);
      ofa = (i == 4);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_win c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
      if (out_valid) ovr_seen.push_back(out_ovr);
    end
    checks++;
    if (ovr_seen.size() != 2 || ovr_seen[0] !== 1'b1 || ovr_seen[1] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags: got %p exp 1,0", ovr_seen);
    end
    ofa = 1'b0;
    tick();
    checks++;
    if (led[4] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b exp 1", led[4]);
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (led[4] !== 1'b0 || obs() !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_clear: got %b exp 0", led[4]);
    end
    ofa = 1'b1;
    tick();
    ofa = 1'b0;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (led[4] !== 1'b1 || obs() !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b exp 1", led[4]);
    end
  endtask

  task automatic test_config();
    int got[$];
    mode = 1'b0; decim = 16'd9; ofa = 1'b0; out_ready = 1'b1;
    en = 1'b0; data_in = 16'd0;
    tick();
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      data_in = 16'(i);
      if (i == 6) decim = 16'd1;
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL cfg c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
      if (out_valid) got.push_back(int'(out_data));
    end
    checks++;
    if (got.size() < 3 || got[0] !== 9 || got[1] !== 11 || got[2] !== 13) begin
      errors++;
      $display("FAIL cfg_values: got %p exp 9,11,13", got);
    end
  endtask

  task automatic test_reset_enable();
    mode = 1'b0; decim = 16'd0; en = 1'b1; out_ready = 1'b0;
    repeat (2) begin
      data_in = 16'($urandom);
      tick();
    end
    mode = 1'b1; avg_log2 = 4'd3;
    repeat (4) begin
      data_in = 16'($urandom);
      tick();
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 34'h0) begin
      errors++;
      $display("FAIL rst_async: got %h exp %h", obs(), 34'h0);
    end
    #2;
    rst_n = 1'b1;
    mode = 1'b0; decim = 16'd0; en = 1'b1; out_ready = 1'b0;
    repeat (2) begin
      data_in = 16'($urandom);
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || obs() !== exp_vec()) begin
      errors++;
      $display("FAIL en_pending: got %h exp %h", obs(), exp_vec());
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== edata || drop_cnt !== 8'd0) begin
        errors++;
        $display("FAIL en_hold c%0d: got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=0", cyc, out_valid, out_data, drop_cnt, edata);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs() !== exp_vec()) begin
      errors++;
      $display("FAIL en_drain: got %h exp %h", obs(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      data_in    = 16'($urandom);
      ofa        = ($urandom_range(0, 9) == 0);
      en         = ($urandom_range(0, 9) != 0);
      mode       = 1'($urandom_range(0, 1));
      decim      = 16'($urandom_range(0, 4));
      avg_log2   = 4'($urandom_range(0, 3));
      out_ready  = ($urandom_range(0, 9) < 7);
      clr_sticky = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL rand c%0d: got %h exp %h", cyc, obs(), exp_vec());
      end
    end
    clr_sticky = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = '0; ofa = 1'b0; en = 1'b1;
    mode = 1'b0; decim = 16'd3; avg_log2 = '0;
    clr_sticky = 1'b0; out_ready = 1'b1;
    model_reset();
    test_reset();
    test_pick();
    test_avg();
    test_back_to_back();
    test_overflow();
    test_config();
    test_reset_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
